// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: scans a 4x8 key matrix one active-low column at a time and debounces every key
// across frames. It publishes the pressed map and a valid/ready press/release event stream.
// Define KEY_EVENT_FIFO_EN to buffer events in a 4-entry FIFO; otherwise a single holding register is used.
module key_matrix_scanner #(
   parameter int N        = 50_000,
   parameter int DEBOUNCE = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rows_in,
   output logic [3:0]  cols,
   output logic [31:0] keys,
   output logic        frame_tick,
   output logic        ev_valid,
   input  logic        ev_ready,
   output logic [4:0]  ev_key,
   output logic        ev_pressed,
   output logic        ev_overflow
);

   localparam int            TW       = $clog2(N);
   localparam logic [TW-1:0] T_LAST   = TW'(N - 1);
   localparam logic [2:0]    CNT_LAST = 3'(DEBOUNCE - 1);

   logic [7:0]    sync1, sync2;
   logic [TW-1:0] timer;
   logic [1:0]    col, col_next, scol;
   logic [7:0]    samp;
   logic          active;
   logic [2:0]    cnt [32];

   logic [2:0]    row;
   logic [4:0]    upd_key;
   logic          upd_en, upd_bit, upd_diff, push, pop;

   // Key index (3-scol)*8+r: for a 2-bit column, 3-scol is simply ~scol.
   assign row      = timer[2:0];
   assign upd_key  = {~scol, row};
   assign upd_en   = active && (timer < TW'(8));
   assign upd_bit  = samp[row];
   assign upd_diff = (upd_bit != keys[upd_key]);
   assign push     = upd_en && upd_diff && (cnt[upd_key] == CNT_LAST);
   assign pop      = ev_valid && ev_ready;
   assign col_next = (timer == T_LAST) ? col + 2'd1 : col;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1      <= 8'hFF;
         sync2      <= 8'hFF;
         timer      <= '0;
         col        <= '0;
         scol       <= '0;
         samp       <= '0;
         active     <= 1'b0;
         cols       <= 4'b1111;
         keys       <= '0;
         frame_tick <= 1'b0;
         // NOTE: the debounce counters are state, not storage, so each one must return to zero on reset.
         for (int i = 0; i < 32; i++) cnt[i] <= '0;
      end else begin
         sync1      <= rows_in;
         sync2      <= sync1;
         timer      <= (timer == T_LAST) ? '0 : timer + TW'(1);
         col        <= col_next;
         cols       <= ~(4'b0001 << col_next);
         frame_tick <= upd_en && (row == 3'd7) && (scol == 2'd3);
         if (timer == T_LAST) begin
            samp   <= ~sync2;
            scol   <= col;
            active <= 1'b1;
         end
         // One row per cycle during the first eight cycles of the following column.
         if (upd_en) begin
            if (!upd_diff) begin
               cnt[upd_key] <= '0;
            end else if (cnt[upd_key] == CNT_LAST) begin
               keys[upd_key] <= upd_bit;
               cnt[upd_key]  <= '0;
            end else begin
               cnt[upd_key] <= cnt[upd_key] + 3'd1;
            end
         end
      end
   end

`ifdef KEY_EVENT_FIFO_EN
   logic [5:0] fifo_mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic       full, do_push;

   assign full     = (count == 3'd4);
   assign do_push  = push && (!full || pop);
   assign ev_valid = (count != 3'd0);
   assign {ev_key, ev_pressed} = fifo_mem[rd_ptr];

   // NOTE: the payload array has no reset; an entry is only visible while ev_valid says it holds data.
   always_ff @(posedge clk) begin
      if (do_push) fifo_mem[wr_ptr] <= {upd_key, upd_bit};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         ev_overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)     rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, do_push} - {2'b00, pop};
         if (push && !do_push) ev_overflow <= 1'b1;
      end
   end
`else
   logic do_push;

   // A pop in the same cycle frees the register, so the new event replaces the old one.
   assign do_push = push && (!ev_valid || pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ev_valid    <= 1'b0;
         ev_key      <= '0;
         ev_pressed  <= 1'b0;
         ev_overflow <= 1'b0;
      end else begin
         if (do_push) begin
            ev_valid   <= 1'b1;
            ev_key     <= upd_key;
            ev_pressed <= upd_bit;
         end else if (pop) begin
            ev_valid <= 1'b0;
         end
         if (push && !do_push) ev_overflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: directed stimulus plus a cycle-level behavioural model of key_matrix_scanner
// (N=16, DEBOUNCE=3). Key presses are driven as a 32-bit map and translated onto the row lines.
module tb_key_matrix_scanner;

   localparam int N        = 16;
   localparam int DEBOUNCE = 3;
`ifdef KEY_EVENT_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   typedef struct {
      int key;
      bit pressed;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rows_in;
   logic [3:0]  cols;
   logic [31:0] keys;
   logic        frame_tick;
   logic        ev_valid;
   logic        ev_ready;
   logic [4:0]  ev_key;
   logic        ev_pressed;
   logic        ev_overflow;

   bit   [31:0] press_map;
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;

   key_matrix_scanner #(.N(N), .DEBOUNCE(DEBOUNCE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rows_in    (rows_in),
      .cols       (cols),
      .keys       (keys),
      .frame_tick (frame_tick),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_key     (ev_key),
      .ev_pressed (ev_pressed),
      .ev_overflow(ev_overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Matrix: the driven (low) column c closes row r when key (3-c)*8+r is pressed.
   always_comb begin
      rows_in = 8'hFF;
      for (int c = 0; c < 4; c++)
         if (cols == ~(4'b0001 << c)) rows_in = ~press_map[(3 - c) * 8 +: 8];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          p;
   int          phase, r, k;
   bit          m_started = 0;
   logic [31:0] m_keys;
   int          m_cnt [32];
   ev_t         mq [$];
   ev_t         e;
   bit          m_ovf, m_tick, m_act;
   logic [7:0]  r1, r2, m_samp;
   int          m_scol;
   logic [3:0]  m_cols;

   always @(posedge clk) begin
      if (!rst_n) begin
         p = 0;
         m_keys = '0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
         mq.delete();
         m_ovf = 0; m_tick = 0; m_act = 0;
         r1 = 8'hFF; r2 = 8'hFF; m_samp = '0; m_scol = 0;
         m_cols = 4'b1111;
         m_started = 1;
      end else begin
         phase = p % N;        // position within the column dwell before this edge
         p++;
         m_tick = 0;
         if (mq.size() != 0 && ev_ready) mq.delete(0);
         if (m_act && phase < 8) begin
            r = phase;
            k = (3 - m_scol) * 8 + r;
            if (m_samp[r] == m_keys[k]) m_cnt[k] = 0;
            else if (m_cnt[k] == DEBOUNCE - 1) begin
               m_keys[k] = m_samp[r];
               m_cnt[k] = 0;
               e.key = k;
               e.pressed = m_samp[r];
               if (mq.size() < CAP) mq.push_back(e);
               else m_ovf = 1;
            end else m_cnt[k]++;
            if (r == 7 && m_scol == 3) m_tick = 1;
         end
         if (phase == N - 1) begin
            m_samp = ~r2;
            m_scol = (p / N - 1) % 4;
            m_act = 1;
         end
         r2 = r1;
         r1 = rows_in;
         m_cols = ~(4'b0001 << ((p / N) % 4));
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         check("cols", cols, m_cols);
         check("keys", keys, m_keys);
         check("frame_tick", frame_tick, m_tick);
         check("ev_valid", ev_valid, mq.size() != 0);
         check("ev_overflow", ev_overflow, m_ovf);
         if (mq.size() != 0) begin
            check("ev_key", ev_key, mq[0].key);
            check("ev_pressed", ev_pressed, mq[0].pressed);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         int budget;
         bit seen;
         budget = 0;
         seen = 0;
         while (!seen && budget < 300) begin
            @(negedge clk);
            budget++;
            if (frame_tick === 1'b1) seen = 1;
         end
         check("tick_seen", seen, 1);
      end
   endtask

   task automatic pop_event();
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
   endtask

   int t1, t2;
   logic [3:0] col_seq [4];

   initial begin
      col_seq[0] = 4'b1101; col_seq[1] = 4'b1011; col_seq[2] = 4'b0111; col_seq[3] = 4'b1110;
      rst_n = 1'b0;
      ev_ready = 1'b0;
      press_map = '0;
      repeat (3) @(negedge clk);
      check("rst_cols", cols, 4'b1111);
      check("rst_keys", keys, 0);
      check("rst_valid", ev_valid, 0);
      check("rst_tick", frame_tick, 0);
      rst_n = 1'b1;

      // Idle scan: column order and dwell.
      @(negedge clk);
      check("first_cols", cols, 4'b1110);
      repeat (14) @(negedge clk);
      check("col0_last", cols, 4'b1110);
      @(negedge clk);
      check("col_step0", cols, col_seq[0]);
      for (int i = 1; i < 4; i++) begin
         repeat (16) @(negedge clk);
         check("col_step", cols, col_seq[i]);
      end
      wait_ticks(1);
      t1 = cyc;
      wait_ticks(1);
      t2 = cyc;
      check("tick_period", t2 - t1, 64);
      check("idle_keys", keys, 0);
      check("idle_valid", ev_valid, 0);

      // Press key 22 (column 1, row 6) and hold.
      press_map[22] = 1'b1;
      wait_ticks(2);
      check("press_2fr_key", keys[22], 0);
      check("press_2fr_valid", ev_valid, 0);
      wait_ticks(1);
      check("press_3fr_key", keys[22], 1);
      check("press_valid", ev_valid, 1);
      check("press_evkey", ev_key, 22);
      check("press_evdir", ev_pressed, 1);
      pop_event();
      check("press_popped", ev_valid, 0);

      // Release key 22.
      press_map[22] = 1'b0;
      wait_ticks(2);
      check("rel_2fr_key", keys[22], 1);
      wait_ticks(1);
      check("rel_3fr_key", keys[22], 0);
      check("rel_evkey", ev_key, 22);
      check("rel_evdir", ev_pressed, 0);
      pop_event();

      // Bounce: 2 frames closed, 1 open, 3 closed -> single press at the end.
      press_map[22] = 1'b1;
      wait_ticks(2);
      press_map[22] = 1'b0;
      wait_ticks(1);
      press_map[22] = 1'b1;
      wait_ticks(2);
      check("bounce_no_key", keys[22], 0);
      check("bounce_no_ev", ev_valid, 0);
      wait_ticks(1);
      check("bounce_key", keys[22], 1);
      check("bounce_evkey", ev_key, 22);
      check("bounce_evdir", ev_pressed, 1);
      pop_event();
      check("bounce_single", ev_valid, 0);
      press_map[22] = 1'b0;
      wait_ticks(3);
      pop_event();
      check("bounce_rel", keys[22], 0);

      // Overflow: whole column 0 pressed with the consumer stalled.
      press_map[31:24] = 8'hFF;
      wait_ticks(3);
      check("ovf_keys", keys, 32'hFF00_0000);
      check("ovf_flag", ev_overflow, 1);
      check("ovf_head", ev_key, 24);
      repeat (10) @(negedge clk);
      check("ovf_stable_key", ev_key, 24);
      check("ovf_stable_dir", ev_pressed, 1);
      for (int i = 0; i < CAP; i++) begin
         check("drain_valid", ev_valid, 1);
         check("drain_key", ev_key, 24 + i);
         pop_event();
      end
      check("drain_empty", ev_valid, 0);

      // Reset in the middle of the column-0 release updates with events pending.
      wait_ticks(1);
      press_map[31:24] = 8'h00;
      wait_ticks(2);
      repeat (12) @(negedge clk);
      check("mid_keys", keys, 32'hF000_0000);
      check("mid_valid", ev_valid, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_keys", keys, 0);
      check("mrst_valid", ev_valid, 0);
      check("mrst_ovf", ev_overflow, 0);
      check("mrst_cols", cols, 4'b1111);
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_restart", cols, 4'b1110);
      wait_ticks(1);
      check("post_keys", keys, 0);
      check("post_valid", ev_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
